control_sequencer: RTL and testbench
====================================

# control_sequencer

Control unit for the SAP-U CPU: holds the instruction register, runs a 5-step microcycle counter (T0–T4), and decodes opcode + step + flags into the control word that drives the RAM/MAR stage, PC, A/B registers, ALU and output register. It sits directly downstream of the RAM, latching the instruction byte the RAM drives onto the bus. It sits directly upstream of the RAM's control inputs through `load_mar_reg_n`, `ram_out_n` and `ram_write_n`.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `prog_mode`  in  1  0 = manual programming (sequencer frozen); 1 = run.
- `bus_in`  in  8  shared bus; the instruction byte is captured from it.
- `carry_flag`, `zero_flag`  in  1 each  registered ALU flags.
- `ir_bus_out`  out  8  `{4'b0000, ir[3:0]}`; valid to the bus only while `ir_out_n`=0.
- `opcode`  out  4  `ir[7:4]`, for debug display.
- `step`  out  3  current T-state, 0–4.
- `halt`  out  1  active-high.
- `pc_enable`  out  1  active-high.
- `subtract`  out  1  active-high.
- Active-low strobes: `load_mar_reg_n`, `ram_out_n` (to RAM `bus_enable_n`), `ram_write_n` (to RAM `control_signal`), `ir_in_n`, `ir_out_n`, `pc_out_n`, `jump_n`, `a_in_n`, `a_out_n`, `b_in_n`, `sum_out_n`, `flags_in_n`, `out_in_n`.

## Operation
- State consists of three fields:
  - `ir[7:0]`
  - `step[2:0]`
  - `halted`
- Control word is combinational from state + flags. Every strobe not listed for the current step is inactive (active-low = 1, active-high = 0).
- Fetch, identical for all opcodes:
  - T0: `pc_out_n`, `load_mar_reg_n`.
  - T1: `ram_out_n`, `ir_in_n`, `pc_enable`.
- Execute (T2/T3/T4):
  - 0 NOP: none.
  - 1 LDA: T2 `ir_out_n`+`load_mar_reg_n`; T3 `ram_out_n`+`a_in_n`.
  - 2 ADD: T2 as LDA; T3 `ram_out_n`+`b_in_n`; T4 `sum_out_n`+`a_in_n`+`flags_in_n`.
  - 3 SUB: as ADD, plus `subtract` in T4.
  - 4 STA: T2 as LDA; T3 `a_out_n`+`ram_write_n`.
  - 5 LDI: T2 `ir_out_n`+`a_in_n`.
  - 6 JMP: T2 `ir_out_n`+`jump_n`.
  - 7 JC: T2 `ir_out_n`; `jump_n` asserted only if `carry_flag`=1.
  - 8 JZ: as JC, gated by `zero_flag`.
  - E OUT: T2 `a_out_n`+`out_in_n`.
  - F HLT: T2 `halt`.
  - 9–D: NOP.
- Step counter: 0→1→2→3→4→0. Always runs all 5 steps; no early termination.
- IR load: at the rising edge ending T1, `ir <= bus_in`.
- Halt: at the rising edge ending T2 with opcode F, set `halted`=1.
  - `step` freezes at 2 and `halt` stays 1.
  - All other strobes stay inactive until reset or `prog_mode`=0.
- Programming mode (`prog_mode`=0):
  - At each rising edge, `step`←0, `ir`←0, `halted`←0.
  - Combinationally, all control outputs are inactive, including T0 fetch strobes, so the RAM is owned by the dipswitches.

## Timing
- Reset (`reset_n`=0, asynchronous): `ir`=0x00, `step`=0, `halted`=0. While reset is held, all control outputs are inactive, `halt`=0, `ir_bus_out`=0x00 and `opcode`=0.
- First rising edge after `reset_n` release with `prog_mode`=1 ends T0. T0 strobes are visible from release until that edge.
- Instruction latency: 5 clocks for every non-HLT instruction. The next instruction's T0 follows immediately.
- Strobes change only after a rising edge; the receiving register samples on the next rising edge.
  - Example: `load_mar_reg_n` in T0 loads the MAR at the T0→T1 edge.
- JC/JZ: the flag is sampled combinationally during T2. A flag change mid-T2 changes `jump_n` in the same cycle.
- `prog_mode` 1→0 mid-instruction: strobes go inactive immediately (combinational) and the state clears at the next edge.
- `prog_mode` 0→1: execution starts at T0 of address given by the PC.
- Reset asserted mid-instruction or while halted: clears immediately regardless of `clk`.
- IR capture and step advance on the same edge are independent, with no hazard.

## Test plan
- Reset then run: `reset_n` 0→1, `prog_mode`=1, bus=0x1E at T1.
  - T0 shows `pc_out_n`=0 and `load_mar_reg_n`=0.
  - After 2 clocks: `ir`=0x1E, `step`=2, `ir_bus_out`=0x0E, `ir_out_n`=0.
- ADD 0x2F: `step` 3 asserts `b_in_n`=0. `step` 4 asserts `sum_out_n`, `a_in_n` and `flags_in_n` = 0 with `subtract`=0. `step` then wraps to 0. SUB 0x3F: same sequence with `subtract`=1 in T4.
- JC 0x75 with `carry_flag`=0 → `jump_n`=1 in T2. Repeat with `carry_flag`=1 → `jump_n`=0 and `ir_bus_out`=0x05. JZ 0x83 with `zero_flag`=1 → `jump_n`=0.
- HLT 0xF0: after the T2 edge, `halt`=1 and `step` stays 2 for 20 clocks with all strobes inactive. Pulsing `reset_n` low gives `halt`=0 and `step`=0.
- `prog_mode` forced to 0 during T3 of STA 0x4A: `ram_write_n` goes 1 immediately. After the next edge, `step`=0 and `ir`=0x00. Outputs stay inactive until `prog_mode`=1.
- Undefined opcode 0xB7: T2–T4 all strobes inactive, then normal fetch of the next instruction.

Source files
------------

// File: rtl/control_sequencer.sv
// SAP-U control unit: instruction register, T0-T4 microcycle counter and the
// combinational decode of opcode/step/flags into the CPU control word.
module control_sequencer (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       prog_mode,
   input  logic [7:0] bus_in,
   input  logic       carry_flag,
   input  logic       zero_flag,
   output logic [7:0] ir_bus_out,
   output logic [3:0] opcode,
   output logic [2:0] step,
   output logic       halt,
   output logic       pc_enable,
   output logic       subtract,
   output logic       load_mar_reg_n,
   output logic       ram_out_n,
   output logic       ram_write_n,
   output logic       ir_in_n,
   output logic       ir_out_n,
   output logic       pc_out_n,
   output logic       jump_n,
   output logic       a_in_n,
   output logic       a_out_n,
   output logic       b_in_n,
   output logic       sum_out_n,
   output logic       flags_in_n,
   output logic       out_in_n
);
   typedef enum logic [2:0] {T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4} step_t;

   // control word held active-high internally; strobes inverted at the ports
   typedef struct packed {
      logic halt, ce, su, mi, ro, ri, ii, io, co, j, ai, ao, bi, eo, fi, oi;
   } ctrl_t;

   step_t      st;
   logic [7:0] ir;
   logic       halted;
   ctrl_t      c;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ir     <= 8'h00;
         st     <= T0;
         halted <= 1'b0;
      end else if (!prog_mode) begin
         ir     <= 8'h00;
         st     <= T0;
         halted <= 1'b0;
      end else if (!halted) begin
         case (st)
            T0: st <= T1;
            T1: begin
               ir <= bus_in;
               st <= T2;
            end
            T2: if (ir[7:4] == 4'hF) halted <= 1'b1;
                else st <= T3;
            T3: st <= T4;
            default: st <= T0;
         endcase
      end
   end

   always_comb begin
      c = '0;
      // programming mode hands the bus and RAM to the dipswitches
      if (reset_n && prog_mode) begin
         if (halted) c.halt = 1'b1;
         else begin
            case (st)
               T0: begin c.co = 1'b1; c.mi = 1'b1; end
               T1: begin c.ro = 1'b1; c.ii = 1'b1; c.ce = 1'b1; end
               T2: case (ir[7:4])
                  4'h1, 4'h2, 4'h3, 4'h4: begin c.io = 1'b1; c.mi = 1'b1; end
                  4'h5: begin c.io = 1'b1; c.ai = 1'b1; end
                  4'h6: begin c.io = 1'b1; c.j = 1'b1; end
                  4'h7: begin c.io = 1'b1; c.j = carry_flag; end
                  4'h8: begin c.io = 1'b1; c.j = zero_flag; end
                  4'hE: begin c.ao = 1'b1; c.oi = 1'b1; end
                  4'hF: c.halt = 1'b1;
                  default: ;
               endcase
               T3: case (ir[7:4])
                  4'h1: begin c.ro = 1'b1; c.ai = 1'b1; end
                  4'h2, 4'h3: begin c.ro = 1'b1; c.bi = 1'b1; end
                  4'h4: begin c.ao = 1'b1; c.ri = 1'b1; end
                  default: ;
               endcase
               T4: if (ir[7:4] == 4'h2 || ir[7:4] == 4'h3) begin
                  c.eo = 1'b1;
                  c.ai = 1'b1;
                  c.fi = 1'b1;
                  c.su = (ir[7:4] == 4'h3);
               end
               default: ;
            endcase
         end
      end
   end

   assign ir_bus_out     = {4'b0000, ir[3:0]};
   assign opcode         = ir[7:4];
   assign step           = st;
   assign halt           = c.halt;
   assign pc_enable      = c.ce;
   assign subtract       = c.su;
   assign load_mar_reg_n = ~c.mi;
   assign ram_out_n      = ~c.ro;
   assign ram_write_n    = ~c.ri;
   assign ir_in_n        = ~c.ii;
   assign ir_out_n       = ~c.io;
   assign pc_out_n       = ~c.co;
   assign jump_n         = ~c.j;
   assign a_in_n         = ~c.ai;
   assign a_out_n        = ~c.ao;
   assign b_in_n         = ~c.bi;
   assign sum_out_n      = ~c.eo;
   assign flags_in_n     = ~c.fi;
   assign out_in_n       = ~c.oi;
endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer against a table-driven instruction model.
module tb_control_sequencer;
   logic       clk = 1'b0;
   logic       reset_n, prog_mode, carry_flag, zero_flag;
   logic [7:0] bus_in;
   logic [7:0] ir_bus_out;
   logic [3:0] opcode;
   logic [2:0] step;
   logic halt, pc_enable, subtract, load_mar_reg_n, ram_out_n, ram_write_n, ir_in_n, ir_out_n;
   logic pc_out_n, jump_n, a_in_n, a_out_n, b_in_n, sum_out_n, flags_in_n, out_in_n;

   control_sequencer dut (
      .clk(clk), .reset_n(reset_n), .prog_mode(prog_mode), .bus_in(bus_in),
      .carry_flag(carry_flag), .zero_flag(zero_flag), .ir_bus_out(ir_bus_out),
      .opcode(opcode), .step(step), .halt(halt), .pc_enable(pc_enable),
      .subtract(subtract), .load_mar_reg_n(load_mar_reg_n), .ram_out_n(ram_out_n),
      .ram_write_n(ram_write_n), .ir_in_n(ir_in_n), .ir_out_n(ir_out_n),
      .pc_out_n(pc_out_n), .jump_n(jump_n), .a_in_n(a_in_n), .a_out_n(a_out_n),
      .b_in_n(b_in_n), .sum_out_n(sum_out_n), .flags_in_n(flags_in_n), .out_in_n(out_in_n)
   );

   always #5 clk = ~clk;

   localparam logic [15:0] HLT = 16'h8000, CE = 16'h4000, SU = 16'h2000, MI = 16'h1000,
                           RO = 16'h0800, RI = 16'h0400, II = 16'h0200, IO = 16'h0100,
                           CO = 16'h0080, J  = 16'h0040, AI = 16'h0020, AO = 16'h0010,
                           BI = 16'h0008, EO = 16'h0004, FI = 16'h0002, OI = 16'h0001;

   int n_chk = 0, n_fail = 0;

   // instruction-level model: current T-state, IR and halt latch
   logic [7:0]  m_ir;
   int          m_step;
   bit          m_halted;
   logic [15:0] tbl [16][3];

   logic [15:0] got_ctrl;
   assign got_ctrl = {halt, pc_enable, subtract, ~load_mar_reg_n, ~ram_out_n, ~ram_write_n,
                      ~ir_in_n, ~ir_out_n, ~pc_out_n, ~jump_n, ~a_in_n, ~a_out_n, ~b_in_n,
                      ~sum_out_n, ~flags_in_n, ~out_in_n};

   function automatic logic [15:0] exp_ctrl();
      logic [15:0] v;
      if (!reset_n || !prog_mode) return 16'h0000;
      if (m_halted) return HLT;
      if (m_step == 0) v = CO | MI;
      else if (m_step == 1) v = RO | II | CE;
      else v = tbl[m_ir[7:4]][m_step-2];
      if (m_ir[7:4] == 4'h7 && !carry_flag) v = v & ~J;
      if (m_ir[7:4] == 4'h8 && !zero_flag) v = v & ~J;
      return v;
   endfunction

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".step"}, {13'd0, step}, m_step[15:0]);
      check({tag, ".op"}, {12'd0, opcode}, {12'd0, m_ir[7:4]});
      check({tag, ".irbus"}, {8'd0, ir_bus_out}, {12'd0, m_ir[3:0]});
      check({tag, ".ctrl"}, got_ctrl, exp_ctrl());
   endtask

   task automatic model_clear();
      m_ir = 8'h00; m_step = 0; m_halted = 0;
   endtask

   // advance the model with the inputs about to be sampled, then take the edge
   task automatic tick();
      if (reset_n) begin
         if (!prog_mode) model_clear();
         else if (!m_halted) begin
            if (m_step == 1) begin m_ir = bus_in; m_step = 2; end
            else if (m_step == 2 && m_ir[7:4] == 4'hF) m_halted = 1;
            else m_step = (m_step + 1) % 5;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic step_chk(input string tag);
      tick();
      check_all(tag);
   endtask

   task automatic run_instr(input logic [7:0] b, input string tag);
      bus_in = b;
      repeat (5) step_chk(tag);
   endtask

   task automatic pulse_reset(input string tag);
      reset_n = 1'b0; #1;
      model_clear();
      check_all(tag);
      reset_n = 1'b1; #1;
   endtask

   initial begin
      for (int o = 0; o < 16; o++) for (int s = 0; s < 3; s++) tbl[o][s] = 16'h0000;
      for (int o = 1; o <= 4; o++) tbl[o][0] = IO | MI;
      tbl[1][1] = RO | AI;
      tbl[2][1] = RO | BI;          tbl[2][2] = EO | AI | FI;
      tbl[3][1] = RO | BI;          tbl[3][2] = EO | AI | FI | SU;
      tbl[4][1] = AO | RI;
      tbl[5][0] = IO | AI;
      tbl[6][0] = IO | J;
      tbl[7][0] = IO | J;
      tbl[8][0] = IO | J;
      tbl[14][0] = AO | OI;
      tbl[15][0] = HLT;

      reset_n = 1'b0; prog_mode = 1'b1; bus_in = 8'h00; carry_flag = 1'b0; zero_flag = 1'b0;
      model_clear();
      #2 check_all("reset");
      @(posedge clk); #1;
      check_all("reset_held");
      reset_n = 1'b1; #1;
      check_all("t0");
      check("t0_mar", {15'd0, load_mar_reg_n}, 16'd0);

      // LDA 0x1E: IR visible two clocks after release
      bus_in = 8'h1E;
      step_chk("lda"); step_chk("lda");
      check("lda_irbus", {8'd0, ir_bus_out}, 16'h000E);
      check("lda_step", {13'd0, step}, 16'd2);
      step_chk("lda"); step_chk("lda"); step_chk("lda");

      run_instr(8'h2F, "add");
      run_instr(8'h3F, "sub");
      carry_flag = 1'b0; run_instr(8'h75, "jc0");
      carry_flag = 1'b1; run_instr(8'h75, "jc1");
      zero_flag  = 1'b1; run_instr(8'h83, "jz1");
      run_instr(8'hB7, "undef");
      run_instr(8'h5C, "ldi");
      run_instr(8'hE0, "out");

      // HLT then 20 frozen clocks, released by reset
      bus_in = 8'hF0;
      repeat (22) step_chk("hlt");
      check("hlt_flag", {15'd0, halt}, 16'd1);
      pulse_reset("hlt_rst");
      check("hlt_cleared", {15'd0, halt}, 16'd0);

      // STA interrupted by programming mode in T3
      bus_in = 8'h4A;
      repeat (3) step_chk("sta");
      check("sta_wr_on", {15'd0, ram_write_n}, 16'd0);
      prog_mode = 1'b0; #1;
      check("sta_wr_off", {15'd0, ram_write_n}, 16'd1);
      check_all("sta_prog");
      repeat (3) step_chk("prog");
      prog_mode = 1'b1; #1;
      check_all("prog_exit");
      run_instr(8'h6D, "jmp");

      repeat (1500) begin
         bus_in     = 8'($urandom);
         carry_flag = 1'($urandom);
         zero_flag  = 1'($urandom);
         prog_mode  = ($urandom_range(0, 19) != 0);
         if ($urandom_range(0, 59) == 0) pulse_reset("rnd_rst");
         step_chk("rnd");
         carry_flag = 1'($urandom);
         zero_flag  = 1'($urandom);
         #1 check_all("rnd_flag");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
